// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - boot/run sequencer: program load, core reset control, run watchdog
//
// Streams a program image into instruction memory while holding the core in
// reset, releases the core after a fixed hold, counts run cycles and stops on
// a mailbox store or watchdog expiry.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), asynchronous active-low reset
//   i_start, i_abort          begin a load (IDLE/DONE only) / return to IDLE
//   i_prog_*, o_prog_ready    program word stream (valid/ready, last marks final word)
//   o_imem_*                  instruction memory write port (one cycle after transfer)
//   o_core_rst                active-high core reset, low only while running
//   i_dmem_*                  monitored core data stores
//   o_busy                    LOAD, HOLD or RUN
//   o_done/o_timeout/o_overflow  sticky status flags
//   o_cycles, o_result        run cycle count, data stored to the mailbox
module core_run_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] DONE_ADDR = 32'h0000_0FFC,
  parameter int          TIMEOUT   = 1000000,
  parameter int          RST_HOLD  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_prog_valid,
  output logic              o_prog_ready,
  input  logic [31:0]       i_prog_data,
  input  logic              i_prog_last,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst,
  input  logic              i_dmem_we,
  input  logic [31:0]       i_dmem_addr,
  input  logic [31:0]       i_dmem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_overflow,
  output logic [31:0]       o_cycles,
  output logic [31:0]       o_result
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX   = '1;
  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [31:0]       CYC_LAST  = 32'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_done;
  logic                r_timeout;
  logic                r_overflow;
  logic [31:0]         r_cycles;
  logic [31:0]         r_result;

  logic                w_xfer;
  logic                w_start;
  logic                w_run;
  logic                w_mbox;
  logic                w_to;
  logic [31:0]         w_cyc_next;

  // Abort suppresses the transfer so a word offered in the abort cycle is dropped.
  assign w_xfer     = (r_state == S_LOAD) && i_prog_valid && !i_abort;
  assign w_start    = i_start && !i_abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run      = (r_state == S_RUN) && !i_abort;
  assign w_mbox     = i_dmem_we && (i_dmem_addr == DONE_ADDR);
  assign w_cyc_next = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;
  // A mailbox store in the same cycle takes priority over the watchdog.
  assign w_to       = w_run && !w_mbox && (w_cyc_next >= CYC_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (i_start) w_next = S_LOAD;
        S_LOAD:         if (w_xfer && (i_prog_last || (r_cnt == CNT_MAX))) w_next = S_HOLD;
        S_HOLD:         if (r_hold_cnt == HOLD_LAST) w_next = S_RUN;
        S_RUN:          if (w_mbox || w_to) w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_prog_ready = 1'b0;
    o_core_rst   = 1'b1;
    o_busy       = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_prog_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_HOLD: o_busy = 1'b1;
      S_RUN: begin
        o_core_rst = 1'b0;
        o_busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt        <= '0;
      r_hold_cnt   <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_cycles     <= '0;
      r_result     <= '0;
    end else begin
      r_imem_we <= w_xfer;

      if (w_start) begin
        r_cnt      <= '0;
        r_done     <= 1'b0;
        r_timeout  <= 1'b0;
        r_overflow <= 1'b0;
        r_cycles   <= '0;
        r_result   <= '0;
      end

      if (w_xfer) begin
        r_imem_addr  <= r_cnt;
        r_imem_wdata <= i_prog_data;
        // The counter parks at the last word rather than wrapping onto address 0.
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + ADDR_W'(1);
        end else if (!i_prog_last) begin
          r_overflow <= 1'b1;
        end
      end

      if (r_state == S_HOLD) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end else begin
        r_hold_cnt <= '0;
      end

      if (w_run) begin
        r_cycles <= w_cyc_next;
        if (w_mbox) begin
          r_done   <= 1'b1;
          r_result <= i_dmem_wdata;
        end else if (w_to) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_done       = r_done;
  assign o_timeout    = r_timeout;
  assign o_overflow   = r_overflow;
  assign o_cycles     = r_cycles;
  assign o_result     = r_result;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl
//
// Two instances share all inputs: A (ADDR_W=10, TIMEOUT=200) and
// B (ADDR_W=3, TIMEOUT=50), so memory-full and watchdog boundaries are
// exercised alongside the normal load/run flow. Instruction memory writes are
// checked against a scoreboard filled as program words are driven.
module tb_core_run_ctrl;

  localparam logic [31:0] MBOX = 32'h0000_0FFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, prog_valid, prog_last, dmem_we;
  logic [31:0] prog_data, dmem_addr, dmem_wdata;

  logic [1:0]  ready_v, we_v, core_rst_v, busy_v, done_v, to_v, ovf_v;
  logic [31:0] wdata_v  [2];
  logic [31:0] cycles_v [2];
  logic [31:0] result_v [2];
  logic [9:0]  addr_a;
  logic [2:0]  addr_b;

  core_run_ctrl #(.ADDR_W(10), .DONE_ADDR(MBOX), .TIMEOUT(200), .RST_HOLD(4)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_prog_valid(prog_valid), .o_prog_ready(ready_v[0]), .i_prog_data(prog_data),
    .i_prog_last(prog_last), .o_imem_we(we_v[0]), .o_imem_addr(addr_a),
    .o_imem_wdata(wdata_v[0]), .o_core_rst(core_rst_v[0]), .i_dmem_we(dmem_we),
    .i_dmem_addr(dmem_addr), .i_dmem_wdata(dmem_wdata), .o_busy(busy_v[0]),
    .o_done(done_v[0]), .o_timeout(to_v[0]), .o_overflow(ovf_v[0]),
    .o_cycles(cycles_v[0]), .o_result(result_v[0])
  );

  core_run_ctrl #(.ADDR_W(3), .DONE_ADDR(MBOX), .TIMEOUT(50), .RST_HOLD(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_prog_valid(prog_valid), .o_prog_ready(ready_v[1]), .i_prog_data(prog_data),
    .i_prog_last(prog_last), .o_imem_we(we_v[1]), .o_imem_addr(addr_b),
    .o_imem_wdata(wdata_v[1]), .o_core_rst(core_rst_v[1]), .i_dmem_we(dmem_we),
    .i_dmem_addr(dmem_addr), .i_dmem_wdata(dmem_wdata), .o_busy(busy_v[1]),
    .o_done(done_v[1]), .o_timeout(to_v[1]), .o_overflow(ovf_v[1]),
    .o_cycles(cycles_v[1]), .o_result(result_v[1])
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t qa[$];
  wr_t qb[$];

  bit mload [2];
  bit movf  [2];
  int mcnt  [2];
  int depth [2];

  typedef struct {
    int          n_words;
    bit          gapped;
    int          store_at;
    logic [31:0] store_data;
    int          run_len;
    logic [1:0]  e_done;
    logic [1:0]  e_to;
    logic [1:0]  e_busy;
    logic [31:0] e_cyc [2];
    logic [31:0] e_res [2];
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] addr_of(input int d);
    return (d == 0) ? {22'd0, addr_a} : {29'd0, addr_b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (rst) begin
      if (we_v[0]) begin
        if (qa.size() == 0) chk("imem_we_unexpected_a", 32'(we_v[0]), 32'd0);
        else begin
          e = qa.pop_front();
          chk("imem_cyc_a", cyc, e.cyc);
          chk("imem_addr_a", addr_of(0), e.addr);
          chk("imem_data_a", wdata_v[0], e.data);
        end
      end
      if (we_v[1]) begin
        if (qb.size() == 0) chk("imem_we_unexpected_b", 32'(we_v[1]), 32'd0);
        else begin
          e = qb.pop_front();
          chk("imem_cyc_b", cyc, e.cyc);
          chk("imem_addr_b", addr_of(1), e.addr);
          chk("imem_data_b", wdata_v[1], e.data);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] data, input logic last);
    wr_t e;
    prog_valid = 1'b1;
    prog_data  = data;
    prog_last  = last;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("prog_ready_%0d", d), 32'(ready_v[d]), 32'(mload[d]));
      if (mload[d]) begin
        e.cyc  = cyc + 1;
        e.addr = mcnt[d];
        e.data = data;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
        if (last) mload[d] = 1'b0;
        else if (mcnt[d] == depth[d] - 1) begin
          mload[d] = 1'b0;
          movf[d]  = 1'b1;
        end
        mcnt[d]++;
      end
    end
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    mload = '{1'b1, 1'b1};
    movf  = '{1'b0, 1'b0};
    mcnt  = '{0, 0};
    step();
    start = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("start_busy_%0d", d), 32'(busy_v[d]), 32'd1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    mload = '{1'b0, 1'b0};
    step();
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_busy_%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("abort_core_rst_%0d", d), 32'(core_rst_v[d]), 32'd1);
    end
  endtask

  task automatic hold_check();
    for (int h = 0; h < 4; h++) begin
      for (int d = 0; d < 2; d++)
        chk($sformatf("hold_core_rst_%0d_c%0d", d, h), 32'(core_rst_v[d]), 32'd1);
      step();
    end
    for (int d = 0; d < 2; d++) chk($sformatf("release_core_rst_%0d", d), 32'(core_rst_v[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    dmem_we = 1'b0; prog_data = '0; dmem_addr = '0; dmem_wdata = '0;
    depth = '{1024, 8};
    mload = '{1'b0, 1'b0};
    movf  = '{1'b0, 1'b0};
    mcnt  = '{0, 0};

    tbl[0] = '{n_words: 8, gapped: 1'b0, store_at: 100, store_data: 32'h1234_5678, run_len: 100,
               e_done: 2'b01, e_to: 2'b10, e_busy: 2'b00,
               e_cyc: '{32'd100, 32'd49}, e_res: '{32'h1234_5678, 32'h0}};
    tbl[1] = '{n_words: 5, gapped: 1'b1, store_at: 0, store_data: 32'h0, run_len: 60,
               e_done: 2'b00, e_to: 2'b10, e_busy: 2'b01,
               e_cyc: '{32'd60, 32'd49}, e_res: '{32'h0, 32'h0}};
    tbl[2] = '{n_words: 4, gapped: 1'b0, store_at: 49, store_data: 32'hA5A5_0049, run_len: 49,
               e_done: 2'b11, e_to: 2'b00, e_busy: 2'b00,
               e_cyc: '{32'd49, 32'd49}, e_res: '{32'hA5A5_0049, 32'hA5A5_0049}};
    tbl[3] = '{n_words: 6, gapped: 1'b1, store_at: 30, store_data: 32'h0BAD_F00D, run_len: 40,
               e_done: 2'b11, e_to: 2'b00, e_busy: 2'b00,
               e_cyc: '{32'd30, 32'd30}, e_res: '{32'h0BAD_F00D, 32'h0BAD_F00D}};

    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_core_rst_%0d", d), 32'(core_rst_v[d]), 32'd1);
      chk($sformatf("rst_busy_%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("rst_ready_%0d", d), 32'(ready_v[d]), 32'd0);
      chk($sformatf("rst_we_%0d", d), 32'(we_v[d]), 32'd0);
      chk($sformatf("rst_flags_%0d", d), {29'd0, done_v[d], to_v[d], ovf_v[d]}, 32'd0);
      chk($sformatf("rst_cycles_%0d", d), cycles_v[d], 32'd0);
      chk($sformatf("rst_result_%0d", d), result_v[d], 32'd0);
      chk($sformatf("rst_addr_%0d", d), addr_of(d), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int r = 0; r < 4; r++) begin
      do_abort();
      start_load();
      for (int i = 0; i < tbl[r].n_words; i++) begin
        if (tbl[r].gapped && i > 0) step();
        send_word(32'hC0DE_0000 + 32'(r * 256 + i), (i == tbl[r].n_words - 1));
      end
      hold_check();
      for (int k = 1; k <= tbl[r].run_len; k++) begin
        dmem_we = 1'b0;
        start   = (k == 5);
        if (k == 10) begin
          dmem_we = 1'b1; dmem_addr = 32'h0000_0FF8; dmem_wdata = 32'hDEAD_BEEF;
        end
        if (k == tbl[r].store_at) begin
          dmem_we = 1'b1; dmem_addr = MBOX; dmem_wdata = tbl[r].store_data;
        end
        step();
      end
      dmem_we = 1'b0;
      start   = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("v%0d_done_%0d", r, d), 32'(done_v[d]), 32'(tbl[r].e_done[d]));
        chk($sformatf("v%0d_timeout_%0d", r, d), 32'(to_v[d]), 32'(tbl[r].e_to[d]));
        chk($sformatf("v%0d_busy_%0d", r, d), 32'(busy_v[d]), 32'(tbl[r].e_busy[d]));
        chk($sformatf("v%0d_core_rst_%0d", r, d), 32'(core_rst_v[d]), 32'(!tbl[r].e_busy[d]));
        chk($sformatf("v%0d_cycles_%0d", r, d), cycles_v[d], tbl[r].e_cyc[d]);
        chk($sformatf("v%0d_result_%0d", r, d), result_v[d], tbl[r].e_res[d]);
        chk($sformatf("v%0d_overflow_%0d", r, d), 32'(ovf_v[d]), 32'(movf[d]));
      end
    end

    // Image without prog_last: B fills its 8 words and refuses the ninth.
    do_abort();
    start_load();
    for (int i = 0; i < 9; i++) send_word(32'h0F00_0000 + 32'(i), 1'b0);
    chk("ovf_b", 32'(ovf_v[1]), 32'(movf[1]));
    chk("ovf_b_set", 32'(ovf_v[1]), 32'd1);
    chk("ovf_a", 32'(ovf_v[0]), 32'd0);
    chk("ovf_ready_b", 32'(ready_v[1]), 32'd0);
    chk("ovf_ready_a", 32'(ready_v[0]), 32'd1);

    // Abort mid-load with a word pending, then abort+start together, then reload.
    do_abort();
    start_load();
    for (int i = 0; i < 3; i++) send_word(32'hAB00_0000 + 32'(i), 1'b0);
    prog_valid = 1'b1;
    prog_data  = 32'hBAD0_0003;
    abort      = 1'b1;
    mload      = '{1'b0, 1'b0};
    step();
    prog_valid = 1'b0;
    abort      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midload_abort_busy_%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("midload_abort_core_rst_%0d", d), 32'(core_rst_v[d]), 32'd1);
      chk($sformatf("midload_abort_ready_%0d", d), 32'(ready_v[d]), 32'd0);
    end
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("abort_wins_busy_%0d", d), 32'(busy_v[d]), 32'd0);
    start_load();
    send_word(32'h5EED_0000, 1'b0);
    send_word(32'h5EED_0001, 1'b1);
    hold_check();
    for (int k = 0; k < 3; k++) step();

    // Asynchronous reset in the middle of RUN.
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async_core_rst_%0d", d), 32'(core_rst_v[d]), 32'd1);
      chk($sformatf("async_busy_%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("async_cycles_%0d", d), cycles_v[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    chk("sb_empty_a", qa.size(), 32'd0);
    chk("sb_empty_b", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
